// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: data width, header field
// positions, destination address encodings and the packet-length helper.
package router_pkg;

    localparam int ROUTER_DATA_W = 8;

    // Header byte layout: [7:2] payload length, [1:0] destination address
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;
    localparam int HDR_ADDR_W   = HDR_ADDR_MSB - HDR_ADDR_LSB + 1;

    // Bytes remaining after a header: payload plus parity must fit here
    localparam int PKT_CNT_W = HDR_LEN_W + 1;

    typedef enum logic [HDR_ADDR_W-1:0] {
        ADDR_P0 = 2'd0,
        ADDR_P1 = 2'd1,
        ADDR_P2 = 2'd2
    } router_addr_e;

    // Number of bytes that follow a header: payload length plus parity
    function automatic logic [PKT_CNT_W-1:0] hdr_pkt_count(
        input logic [ROUTER_DATA_W-1:0] hdr
    );
        return PKT_CNT_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for router_fifo: synchronous write, asynchronous read,
// no reset (contents are qualified by the pointers in the parent).
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = ROUTER_DATA_W + 1
)(
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port: one entry per accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router. Stores {hdr_flag, data}
// per entry, reports full/empty to the synchronizer, and tracks packet
// boundaries on the read side so pkt_end marks the parity byte on dout.
// Optional feature: define ROUTER_FIFO_OCC_EN to add the registered
// occupancy output occ.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ROUTER_DATA_W
)(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     soft_rst,
    input  logic                     we,
    input  logic                     lfd,
    input  logic [WIDTH-1:0]         din,
    input  logic                     re,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
`ifdef ROUTER_FIFO_OCC_EN
    output logic [$clog2(DEPTH):0]   occ,
`endif
    output logic                     pkt_end
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]       dout_q, dout_d;
    logic                   pkt_end_q, pkt_end_d;
    logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic                   wr_acc;
    logic                   rd_acc;
    logic                   mem_we;
    logic [WIDTH:0]         rd_entry;
    logic                   rd_is_hdr;

    // Flags decode the registered pointers only, so they reflect state
    // before this cycle's read; a write while full is dropped even if a
    // read frees a slot in the same cycle.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign wr_acc = we & ~full;
    assign rd_acc = re & ~empty;

    // A write coinciding with either reset is discarded
    assign mem_we = wr_acc & rstn & ~soft_rst;

    router_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (WIDTH + 1)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata ({lfd, din}),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_entry)
    );

    assign rd_is_hdr = rd_entry[WIDTH];

    // Next-state: pointer advance, read data capture and packet tracking
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dout_d    = dout_q;
        pkt_cnt_d = pkt_cnt_q;
        pkt_end_d = 1'b0;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            dout_d   = rd_entry[WIDTH-1:0];
            if (rd_is_hdr) begin
                // Header: count payload plus parity byte still to come
                pkt_cnt_d = hdr_pkt_count(rd_entry[ROUTER_DATA_W-1:0]);
            end else if (pkt_cnt_q != '0) begin
                pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
                pkt_end_d = (pkt_cnt_q == PKT_CNT_W'(1));
            end
            // Stray byte outside any packet: delivered, counter stays 0
        end

        // Timeout clear from the synchronizer behaves exactly like reset
        if (soft_rst) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            dout_d    = '0;
            pkt_cnt_d = '0;
            pkt_end_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            dout_q    <= '0;
            pkt_cnt_q <= '0;
            pkt_end_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dout_q    <= dout_d;
            pkt_cnt_q <= pkt_cnt_d;
            pkt_end_q <= pkt_end_d;
        end
    end

    assign dout    = dout_q;
    assign pkt_end = pkt_end_q;

`ifdef ROUTER_FIFO_OCC_EN
    logic [AW:0] occ_q;
    logic [AW:0] occ_d;

    // Occupancy follows the next pointer values so it moves with them
    always_comb begin
        occ_d = wr_ptr_d - rd_ptr_d;
    end

    // Occupancy register, cleared with the pointers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Testbench for router_fifo: directed scenarios plus random traffic,
// checked by a queue-based reference model and a scoreboard monitor.
module tb_router_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic       soft_rst;
    logic       we;
    logic       lfd;
    logic [7:0] din;
    logic       re;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       pkt_end;
`ifdef ROUTER_FIFO_OCC_EN
    logic [4:0] occ;
`endif

    always #5 clk = ~clk;

    router_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .soft_rst (soft_rst),
        .we       (we),
        .lfd      (lfd),
        .din      (din),
        .re       (re),
        .dout     (dout),
        .full     (full),
        .empty    (empty),
`ifdef ROUTER_FIFO_OCC_EN
        .occ      (occ),
`endif
        .pkt_end  (pkt_end)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: buffered entries {hdr, data}, bytes left in packet
    logic [8:0] mq[$];
    int         remaining = 0;
    logic [7:0] held = 8'h00;
    logic [8:0] exp_q[$];       // {pkt_end, dout} expected for each accepted read
    bit         rd_done = 0;
    bit         mon_en = 0;
    logic [8:0] ent;
    bit         w_ok, r_ok, endp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the buffer rules to the same inputs the DUT samples
    always @(posedge clk) begin
        rd_done = 0;
        if (rstn !== 1'b1 || soft_rst === 1'b1) begin
            mq.delete();
            exp_q.delete();
            remaining = 0;
            held = 8'h00;
        end else begin
            w_ok = (we === 1'b1) && (mq.size() < DEPTH);
            r_ok = (re === 1'b1) && (mq.size() > 0);
            if (r_ok) begin
                ent  = mq.pop_front();
                endp = 0;
                if (ent[8]) begin
                    remaining = int'(ent[7:2]) + 1;
                end else if (remaining > 0) begin
                    remaining = remaining - 1;
                    endp = (remaining == 0);
                end
                held = ent[7:0];
                exp_q.push_back({endp, ent[7:0]});
                rd_done = 1;
            end
            if (w_ok) mq.push_back({lfd, din});
        end
    end

    // Monitor: compare flags every cycle and pop the scoreboard on each read
    always @(negedge clk) begin
        logic [8:0] x;
        if (mon_en) begin
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
`ifdef ROUTER_FIFO_OCC_EN
            chk("occ", 32'(occ), 32'(mq.size()));
`endif
            if (rd_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got read expected none at %0t", $time);
                end else begin
                    x = exp_q.pop_front();
                    chk("dout", 32'(dout), 32'(x[7:0]));
                    chk("pkt_end", 32'(pkt_end), 32'(x[8]));
                end
            end else begin
                chk("dout_hold", 32'(dout), 32'(held));
                chk("pkt_end_idle", 32'(pkt_end), 32'(0));
            end
        end
    end

    task automatic cyc(input logic w, input logic l, input logic [7:0] d,
                       input logic r, input logic s);
        @(negedge clk);
        rstn = 1'b1; we = w; lfd = l; din = d; re = r; soft_rst = s;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        rstn = 1'b0; we = 1'b0; lfd = 1'b0; din = 8'h00; re = 1'b0; soft_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic w, l, r, s;
        logic [7:0] d;
        rstn = 1'b0; soft_rst = 1'b0; we = 1'b0; lfd = 1'b0; din = 8'h00; re = 1'b0;
        @(posedge clk);
        mon_en = 1;

        // Reset state
        idle();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_pkt_end", 32'(pkt_end), 32'h0);

        // Fill to full, drop extra write, drain in order
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        idle();
        chk("full_after16", 32'(full), 32'h1);
        cyc(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("drain_last", 32'(dout), 32'h10);
        chk("empty_after_drain", 32'(empty), 32'h1);

        // Packet with length 3: pkt_end only on the parity byte
        rst_cycle();
        cyc(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'hA3, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h5E, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("parity_dout", 32'(dout), 32'h5E);
        chk("parity_pkt_end", 32'(pkt_end), 32'h1);

        // Zero-length header, parity, then a stray byte
        cyc(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming at occupancy 8 across pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
            chk("stream_notfull", 32'(full), 32'h0);
            chk("stream_notempty", 32'(empty), 32'h0);
        end

        // Soft reset while writing
        rst_cycle();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("soft_empty", 32'(empty), 32'h1);
        chk("soft_dout", 32'(dout), 32'h0);
        idle();
        chk("soft_read_noeffect", 32'(dout), 32'h0);
        chk("soft_still_empty", 32'(empty), 32'h1);

        // Read while empty after draining
        cyc(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("empty_read_hold", 32'(dout), 32'h3C);

`ifdef ROUTER_FIFO_OCC_EN
        rst_cycle();
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("occ_five", 32'(occ), 32'd5);
        rst_cycle();
        idle();
        chk("occ_reset", 32'(occ), 32'd0);
`endif

        // Random traffic with short packets, stray bytes and soft resets
        rst_cycle();
        for (int i = 0; i < 1500; i++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            l = w && ($urandom_range(0, 5) == 0);
            d = l ? {6'($urandom_range(0, 4)), 2'($urandom_range(0, 2))} : 8'($urandom);
            s = ($urandom_range(0, 299) == 0);
            cyc(w, l, d, r, s);
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output buffer of the 1x3 router, instantiated three times. It sits directly downstream of the synchronizer and takes one write-enable bit and one soft-reset strobe from it. It returns the full and empty flags the synchronizer uses for flow control and valid generation. Each entry stores a data byte plus a header marker, so the read side can track packet boundaries and flag the parity byte.

## Interface
- DEPTH, 16, number of entries; power of two, at least 4.
- WIDTH, 8, data byte width.
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset, synchronous, active-low.
- soft_rst  in  1  synchronous clear strobe (synchronizer timeout); same effect as reset.
- we  in  1  write enable (one bit of the synchronizer's wr_enb).
- lfd  in  1  marks the current write as a packet header byte.
- din  in  WIDTH  write data; header format is din[7:2] = payload length, din[1:0] = destination address.
- re  in  1  read enable from the destination port.
- dout  out  WIDTH  registered read data.
- full  out  1  all DEPTH entries occupied.
- empty  out  1  no entries occupied.
- pkt_end  out  1  one-cycle pulse, concurrent with dout presenting a packet's parity byte.

## Operation
- Storage: DEPTH x (WIDTH+1) array holding {hdr_flag, data}.
- Pointers: write and read pointers of log2(DEPTH)+1 bits each, so wrap-around is natural.
  - empty = pointers equal.
  - full = MSBs differ and the lower bits are equal.
- Write accepted when we=1 and full=0. Stores {lfd, din} at wr_ptr, then increments wr_ptr. A write while full is dropped and no state changes.
- Read accepted when re=1 and empty=0. Loads dout with the data at rd_ptr, then increments rd_ptr. A read while empty is ignored and dout holds its value.
- Simultaneous accepted read and write: both happen. Occupancy is unchanged.
- Write while full in the same cycle as a read: the write is still dropped, because full is evaluated before the read.
- Packet counter pkt_cnt is 7 bits. Reset value is 0.
  - Accepted read of an entry with hdr_flag=1: pkt_cnt <= data[7:2] + 1, covering the payload plus the parity byte.
  - Accepted read of an entry with hdr_flag=0 and pkt_cnt != 0: pkt_cnt decrements.
  - When that decrement takes pkt_cnt from 1 to 0, pkt_end is asserted for the cycle dout shows that byte.
  - Accepted read with hdr_flag=0 and pkt_cnt=0 is a stray byte: data is delivered, pkt_cnt stays 0, no pkt_end.
- Header with length 0: pkt_cnt loads 1, and the next read (parity byte) raises pkt_end.
- soft_rst=1 has identical effect to rstn=0. Priority is rstn, then soft_rst, then read/write. A write coinciding with soft_rst is discarded.
- Reset mid-packet: buffered contents are abandoned, pkt_cnt returns to 0, and the next byte read is not assumed to be a header unless flagged.

## Timing
- Reset values: dout=0, full=0, empty=1, pkt_end=0, pointers=0, pkt_cnt=0 (plus occ=0 when enabled).
- Read latency: dout is valid on the clock after the cycle in which re is accepted.
- Flag latency: full and empty are combinational decodes of the registered pointers. They change in the cycle after the accepted write or read that moves a pointer.
- Write-to-read: a byte written in cycle N can be accepted for read in cycle N+1; dout shows it in N+2.
- pkt_end is registered and aligned with dout.

## Configuration
- ROUTER_FIFO_OCC_EN: when defined, adds output occ (log2(DEPTH)+1 bits) = wr_ptr - rd_ptr, registered with the pointers. It is 0 on reset or soft reset and equals DEPTH when full.
- When undefined, the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package router_pkg holds:
  - ROUTER_DATA_W = 8.
  - Header field constants: HDR_LEN_MSB = 7, HDR_LEN_LSB = 2, HDR_ADDR_MSB = 1, HDR_ADDR_LSB = 0.
  - Address encodings 0, 1, 2.
- One sub-module, router_fifo_mem: a synchronous-write, asynchronous-read array with no reset. The pointer, flag and packet logic stay in router_fifo.

## Test plan
- Reset, then 16 writes of 0x01..0x10 with no reads:
  - full=1 one cycle after the 16th write;
  - a 17th write of 0xFF is dropped;
  - 16 reads return 0x01..0x10 and empty=1 after the last.
- Header 0x0C (length 3, lfd=1) followed by 0xA1, 0xA2, 0xA3 and parity 0x5E, then read all five: pkt_end pulses only with dout=0x5E.
- Simultaneous write and read on every cycle for 40 cycles starting at occupancy 8:
  - data order preserved across pointer wrap;
  - full=0 and empty=0 throughout.
- Load 5 bytes, then pulse soft_rst for one cycle while we=1: empty=1, dout=0, and a read the next cycle has no effect.
- Read while empty (re=1, 3 cycles) after draining: dout holds its last value, and pointers and pkt_cnt are unchanged.
- With ROUTER_FIFO_OCC_EN defined, write 7 bytes and read 2: occ=5; after a subsequent rstn=0 cycle, occ=0.
